// File: rtl/shiftleft_seq.sv
`default_nettype none
// ============================================================================
// Module      : shiftleft_seq
// Description : Iterative 32-bit logical left shifter. An operand and a 5-bit
//               shift amount are accepted on a start handshake. The shift is
//               resolved one power-of-two stage per cycle (16, 8, 4, 2, 1),
//               and a registered result is then presented with a one-cycle
//               ready pulse. Latency is a fixed 5 cycles from the accepting
//               edge, whatever the shift amount.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Configuration macro:
//   SHIFTLEFT_OVERFLOW_EN - when defined, data_exception flags any 1 bit
//                           that was shifted out. When undefined,
//                           data_exception is tied to 0 and the port remains.
// ----------------------------------------------------------------------------
// Ports:
//   clock          in   1      rising-edge clock
//   reset          in   1      asynchronous active-high reset
//   ctrl_start     in   1      request a shift (ignored while busy)
//   data_operand   in   WIDTH  value to shift
//   ctrl_shiftamt  in   5      shift amount 0..31
//   result         out  WIDTH  last completed result, held until next one
//   data_resultRDY out  1      one-cycle pulse marking result valid
//   data_exception out  1      shifted-out-one flag, valid with ready
//   busy           out  1      high while a shift is in progress
// ============================================================================
module shiftleft_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_start,
    input  logic [WIDTH-1:0] data_operand,
    input  logic [4:0]       ctrl_shiftamt,
    output logic [WIDTH-1:0] result,
    output logic             data_resultRDY,
    output logic             data_exception,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   work_q,   work_d;
    logic [4:0]         amt_q,    amt_d;
    logic [2:0]         stg_q,    stg_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               rdy_q,    rdy_d;
    logic               busy_q,   busy_d;
`ifdef SHIFTLEFT_OVERFLOW_EN
    logic               ovf_q,    ovf_d;
    logic               exc_q,    exc_d;
`endif

    // Stage distance is 2^stg (16, 8, 4, 2, 1).
    logic [4:0]         w_dist;
    logic               w_stage_en;
    logic [WIDTH-1:0]   w_shifted;

    assign w_dist     = 5'd1 << stg_q;
    // Bit stg of the latched amount selects whether this stage shifts.
    assign w_stage_en = |(amt_q & w_dist);
    assign w_shifted  = work_q << w_dist;

`ifdef SHIFTLEFT_OVERFLOW_EN
    // The top 2^stg bits of work are the ones pushed out by this stage.
    logic [WIDTH-1:0]   w_topmask;
    assign w_topmask  = ~({WIDTH{1'b1}} >> w_dist);
`endif

    // ------------------------------------------------------------------
    // Next-state and output-register logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        amt_d    = amt_q;
        stg_d    = stg_q;
        result_d = result_q;
        rdy_d    = 1'b0;
        busy_d   = 1'b0;
`ifdef SHIFTLEFT_OVERFLOW_EN
        ovf_d    = ovf_q;
        exc_d    = exc_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (ctrl_start) begin
                    work_d  = data_operand;
                    amt_d   = ctrl_shiftamt;
                    stg_d   = 3'd4;
`ifdef SHIFTLEFT_OVERFLOW_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = S_SHIFT;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_SHIFT: begin
                if (w_stage_en) begin
                    work_d = w_shifted;
`ifdef SHIFTLEFT_OVERFLOW_EN
                    ovf_d  = ovf_q | (|(work_q & w_topmask));
`endif
                end
                if (stg_q == 3'd0) begin
                    // Last stage: publish the post-shift value directly.
                    result_d = work_d;
`ifdef SHIFTLEFT_OVERFLOW_EN
                    exc_d    = ovf_d;
`endif
                    rdy_d    = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    stg_d    = stg_q - 3'd1;
                    busy_d   = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            work_q   <= '0;
            amt_q    <= '0;
            stg_q    <= '0;
            result_q <= '0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            amt_q    <= amt_d;
            stg_q    <= stg_d;
            result_q <= result_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

`ifdef SHIFTLEFT_OVERFLOW_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
            exc_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            exc_q <= exc_d;
        end
    end

    assign data_exception = exc_q;
`else
    assign data_exception = 1'b0;
`endif

    assign result         = result_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_shiftleft_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_shiftleft_seq
// Description : Scoreboard bench for shiftleft_seq. Stimulus pushes the
//               expected result, exception flag and completion cycle. A
//               monitor pops and compares on every ready pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shiftleft_seq;

    logic        clock;
    logic        reset;
    logic        ctrl_start;
    logic [31:0] data_operand;
    logic [4:0]  ctrl_shiftamt;
    logic [31:0] result;
    logic        data_resultRDY;
    logic        data_exception;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          when;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    shiftleft_seq #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_start     (ctrl_start),
        .data_operand   (data_operand),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .result         (result),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic exp_exc(input logic [31:0] op, input logic [4:0] amt);
`ifdef SHIFTLEFT_OVERFLOW_EN
        logic [63:0] w;
        w = {32'd0, op} << amt;
        return |w[63:32];
`else
        return (op == 32'd0) && (amt == 5'd31) && 1'b0;
`endif
    endfunction

    // Called right after a negedge; returns at the negedge after the
    // accepting edge E0.
    task automatic issue(input logic [31:0] op, input logic [4:0] amt, input bit push);
        exp_t e;
        ctrl_start    = 1'b1;
        data_operand  = op;
        ctrl_shiftamt = amt;
        @(posedge clock);
        #1;
        if (push) begin
            e.res  = op << amt;
            e.exc  = exp_exc(op, amt);
            e.when = cyc + 5;
            sb.push_back(e);
        end
        ctrl_start = 1'b0;
        @(negedge clock);
    endtask

    // Monitor: compares on every ready pulse.
    always @(negedge clock) begin
        if (data_resultRDY) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdy: got a pulse at cycle %0d, required none", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("result",    64'(result),         64'(mon_e.res));
                check("exception", 64'(data_exception), 64'(mon_e.exc));
                check("latency",   64'(cyc),            64'(mon_e.when));
            end
        end
    end

    initial begin
        reset         = 1'b1;
        ctrl_start    = 1'b0;
        data_operand  = 32'd0;
        ctrl_shiftamt = 5'd0;

        @(negedge clock);
        check("reset_result", 64'(result),         64'd0);
        check("reset_rdy",    64'(data_resultRDY), 64'd0);
        check("reset_exc",    64'(data_exception), 64'd0);
        check("reset_busy",   64'(busy),           64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // Basic shift.
        issue(32'h0000_0001, 5'd31, 1'b1);
        repeat (6) @(negedge clock);

        // Overflow vectors.
        issue(32'h4000_0000, 5'd2, 1'b1);
        repeat (6) @(negedge clock);
        issue(32'h8000_0001, 5'd1, 1'b1);
        repeat (6) @(negedge clock);
        issue(32'h0001_0000, 5'd15, 1'b1);
        repeat (6) @(negedge clock);
        issue(32'h0001_0000, 5'd16, 1'b1);
        repeat (6) @(negedge clock);

        // Zero amount, then back-to-back start in the DONE cycle.
        issue(32'hDEAD_BEEF, 5'd0, 1'b1);
        repeat (5) @(negedge clock);
        check("b2b_done_rdy", 64'(data_resultRDY), 64'd1);
        issue(32'h0000_FFFF, 5'd8, 1'b1);
        repeat (6) @(negedge clock);

        // Start while busy is ignored; busy profile is unchanged.
        issue(32'h0000_0003, 5'd4, 1'b1);
        check("busy_k0", 64'(busy), 64'd1);
        for (int k = 1; k <= 5; k++) begin
            if (k == 2) begin
                ctrl_start    = 1'b1;
                data_operand  = 32'hFFFF_FFFF;
                ctrl_shiftamt = 5'd3;
            end
            @(negedge clock);
            ctrl_start = 1'b0;
            check($sformatf("busy_k%0d", k), 64'(busy), (k < 5) ? 64'd1 : 64'd0);
        end
        repeat (8) @(negedge clock);

        // Reset mid-shift: no pulse, result cleared, fresh op completes.
        issue(32'h1234_5678, 5'd4, 1'b0);
        @(negedge clock);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_result", 64'(result),         64'd0);
        check("midrst_busy",   64'(busy),           64'd0);
        check("midrst_rdy",    64'(data_resultRDY), 64'd0);
        check("midrst_exc",    64'(data_exception), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        check("midrst_hold", 64'(result), 64'd0);
        issue(32'h1234_5678, 5'd4, 1'b1);
        repeat (6) @(negedge clock);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
